// File: rtl/attest_scheduler.sv
// Attestation request scheduler: round-robin grant of two requesters, then PC tracking
// through the protected routine window. Optional run watchdog: ATTEST_RUN_WDT_EN.
module attest_scheduler #(
  parameter logic [15:0] FST_ADDR      = 16'h1234,
  parameter logic [15:0] LST_ADDR      = 16'h123F,
  parameter logic [15:0] ENTRY_TIMEOUT = 16'd1024,
  parameter logic [7:0]  RESET_HOLD    = 8'd16,
  parameter logic [15:0] RUN_MAX       = 16'd4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic        trig,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        reset_req
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ENTRY,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;
  logic [1:0]  r_gnt;
  logic        r_rr;
  logic [2:0]  r_err_code;
  logic [2:0]  w_err_code_next;
  logic [1:0]  w_grant;
  logic        w_in_window;
  logic        w_mid_entry;
  logic        w_err_first;

  assign w_in_window = (pc >= FST_ADDR) && (pc <= LST_ADDR);
  assign w_mid_entry = (pc > FST_ADDR) && (pc <= LST_ADDR);
  // r_cnt only equals the full hold value on the first ERROR cycle, since it counts down
  assign w_err_first = (r_state == S_ERROR) && (r_cnt == {8'd0, RESET_HOLD});

`ifdef ATTEST_RUN_WDT_EN
  logic [15:0] r_run_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run_cnt <= 16'd0;
    end else if ((r_state == S_WAIT_ENTRY) && (w_state_next == S_RUN)) begin
      r_run_cnt <= RUN_MAX;
    end else if (r_state == S_RUN) begin
      r_run_cnt <= r_run_cnt - 16'd1;
    end
  end
`else
  logic w_unused_run_max;
  assign w_unused_run_max = ^RUN_MAX;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_err_code_next = r_err_code;
    w_grant         = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          w_state_next = S_WAIT_ENTRY;
          w_grant      = (req == 2'b11) ? (r_rr ? 2'b10 : 2'b01) : req;
        end
      end
      S_WAIT_ENTRY: begin
        if (pc == FST_ADDR) begin
          w_state_next = S_RUN;
        end else if (w_mid_entry) begin
          w_state_next    = S_ERROR;
          w_err_code_next = 3'b011;
        end else if ((req & r_gnt) == 2'b00) begin
          w_state_next = S_IDLE;
        end else if (r_cnt <= 16'd1) begin
          w_state_next    = S_ERROR;
          w_err_code_next = 3'b001;
        end
      end
      S_RUN: begin
        if (pc == LST_ADDR) begin
          w_state_next = S_DONE;
        end else if (!w_in_window) begin
          w_state_next    = S_ERROR;
          w_err_code_next = 3'b010;
`ifdef ATTEST_RUN_WDT_EN
        end else if (r_run_cnt <= 16'd1) begin
          w_state_next    = S_ERROR;
          w_err_code_next = 3'b100;
`endif
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      S_ERROR: begin
        if (r_cnt <= 16'd1) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Shared down-counter: entry timeout in WAIT_ENTRY, reset hold in ERROR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= 16'd0;
      r_gnt      <= 2'b00;
      r_err_code <= 3'b000;
    end else if ((r_state == S_IDLE) && (w_state_next == S_WAIT_ENTRY)) begin
      r_gnt <= w_grant;
      r_cnt <= ENTRY_TIMEOUT;
    end else if ((r_state != S_ERROR) && (w_state_next == S_ERROR)) begin
      r_cnt      <= {8'd0, RESET_HOLD};
      r_err_code <= w_err_code_next;
    end else if ((r_state == S_WAIT_ENTRY) || (r_state == S_ERROR)) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr <= 1'b0;
    end else if ((r_state == S_DONE) ||
                 ((r_state == S_ERROR) && (w_state_next == S_IDLE))) begin
      r_rr <= ~r_rr;
    end
  end

  always_comb begin
    gnt       = (r_state == S_IDLE) ? 2'b00 : r_gnt;
    trig      = (r_state == S_WAIT_ENTRY);
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    err       = w_err_first;
    err_code  = r_err_code;
    reset_req = (r_state == S_ERROR);
  end

endmodule
